fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the pipelined datapath core; drives the core's 17-bit `instr` input.
- Holds a loadable instruction memory and a program counter (PC).
- Sequences fetch with an IDLE/RUN/HALT state machine and presents one registered instruction per cycle.
- Inserts a NOP bubble on stall or after halt, so the core never re-executes a held instruction.

Parameters:
IW, 17, instruction width; matches core decode {opcode[1:0], RD[4:0], RS1[4:0], RS2[4:0]}
DEPTH, 64, instruction memory words
AW, 6, PC/address width; DEPTH must equal 2**AW
NOP_INSTR, 17'h00000, bubble value driven on instr when no valid instruction
HALT_INSTR, 17'h1FFFF, sentinel word that ends a program

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
ld_we  in  1  loader write enable; honoured only in IDLE or HALT
ld_addr  in  AW  loader write address
ld_data  in  IW  loader write data
start  in  1  single-cycle pulse; begins execution at address 0 (honoured in IDLE or HALT)
stall  in  1  in RUN: insert bubble, hold PC
instr  out  IW  registered instruction to the core
pc  out  AW  address of the next word to fetch
valid  out  1  instr holds a real fetched instruction
busy  out  1  high while in RUN
done  out  1  high while in HALT

Behaviour:
- Reset (sync, active-high) sets: state=IDLE, pc=0, instr=NOP_INSTR, valid=0, busy=0, done=0.
  - Memory contents are not reset.
  - rst has priority over every other input, including mid-RUN; no further fetch occurs after it.
- Memory: synchronous write; read of mem[pc] is combinational and captured into the instr register.
- IDLE:
  - ld_we=1 writes mem[ld_addr] <= ld_data.
  - start=1 -> RUN with pc=0.
  - instr=NOP_INSTR, valid=0.
- RUN (busy=1), evaluated each edge in this priority:
  - stall=1: instr<=NOP_INSTR, valid<=0, pc holds.
  - mem[pc]==HALT_INSTR: instr<=NOP_INSTR, valid<=0, pc holds, -> HALT. The sentinel itself is never issued.
  - pc==DEPTH-1: instr<=mem[pc], valid<=1, pc holds, -> HALT. No wrap-around.
  - otherwise: instr<=mem[pc], valid<=1, pc<=pc+1.
  - ld_we and start are ignored.
- HALT (done=1):
  - Entry edge clears valid/instr to NOP_INSTR, except the pc==DEPTH-1 case, which issues its last word on that entry edge.
  - On the following edge: instr=NOP_INSTR, valid=0.
  - ld_we is honoured.
  - start -> RUN with pc=0, done<=0.
- Latency: start sampled at edge N -> busy=1 after N; mem[0] appears on instr with valid=1 after edge N+1, if stall=0 at N+1.
- Simultaneous ld_we and start in IDLE/HALT: the write completes at the same edge as the transition, so it is visible to the first fetch (including address 0).
- Stall on a HALT_INSTR word: the stall wins; the halt is taken on the first unstalled cycle.

Optional Feature:
- Macro: FETCH_CNT_EN.
- Defined:
  - Adds output port fetched_cnt [31:0]: count of instructions issued with valid=1.
  - Cleared by rst and on each start that enters RUN.
  - Wraps modulo 2**32.
  - Bubbles and HALT_INSTR are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN with pc=5 -> next cycle state IDLE, pc=0, instr=17'h00000, valid=0, busy=0, done=0.
- Load mem[0..2]=17'h04443, 17'h08C85, 17'h1FFFF; start pulse -> instr=04443 then 08C85 with valid=1 on consecutive cycles; then instr=NOP_INSTR, valid=0, done=1, pc=2.
- Program of 4 instructions with stall=1 for 2 cycles after the 2nd issue -> two NOP bubbles with valid=0, pc held at 2; 3rd and 4th instructions follow unchanged.
- Fill all 64 words with non-halt values, start -> 64 valid issues; pc stays at 63 and done=1 with no wrap to 0.
- In HALT, ld_we writes mem[0]=17'h0A0A1 in the same cycle as start -> first issued instr=0A0A1; ld_we pulses during RUN leave memory unchanged.
- With FETCH_CNT_EN defined, a 3-instruction program with 1 stall -> fetched_cnt=3 at done; a restart clears it to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: loadable instruction memory, PC and IDLE/RUN/HALT sequencer
// feeding one registered instruction per cycle. Optional issue counter under FETCH_CNT_EN.
module fetch_stage #(
    parameter int              IW         = 17,
    parameter int              DEPTH      = 64,
    parameter int              AW         = 6,
    parameter logic [IW-1:0]   NOP_INSTR  = 17'h00000,
    parameter logic [IW-1:0]   HALT_INSTR = 17'h1FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [IW-1:0]   ld_data,
    input  logic            start,
    input  logic            stall,
    output logic [IW-1:0]   instr,
    output logic [AW-1:0]   pc,
    output logic            valid,
    output logic            busy,
    output logic            done
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0]     fetched_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [IW-1:0]   mem_q [DEPTH];
    logic [IW-1:0]   rd_word_s;
    logic            ld_ok_s;
    logic            start_ok_s;

    assign rd_word_s  = mem_q[pc_q];
    assign ld_ok_s    = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign start_ok_s = start && ld_ok_s;

    // Loader port: writes only outside RUN, and never on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && ld_we && ld_ok_s) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // Sequencer next state; every path not issuing a word drives a bubble.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                    pc_d    = ZERO_ADDR;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    state_d = state_q;
                    pc_d    = pc_q;
                    busy_d  = 1'b0;
                    done_d  = (state_q == ST_HALT);
                end
            end
            ST_RUN: begin
                // Stall outranks the sentinel so a stalled HALT word halts later.
                if (stall) begin
                    pc_d = pc_q;
                end else if (rd_word_s == HALT_INSTR) begin
                    state_d = ST_HALT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (pc_q == LAST_ADDR) begin
                    instr_d = rd_word_s;
                    valid_d = 1'b1;
                    state_d = ST_HALT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    instr_d = rd_word_s;
                    valid_d = 1'b1;
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = ZERO_ADDR;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= ZERO_ADDR;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Issue counter restarts with every accepted start.
    always_comb begin
        if (start_ok_s) begin
            cnt_d = 32'd0;
        end else if (valid_d) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetched_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: program-level reference model (expected issue
// stream per program) with directed and randomized stalls and loader noise.
module tb_fetch_stage;

    localparam logic [16:0] NOP  = 17'h00000;
    localparam logic [16:0] HALT = 17'h1FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_we;
    logic [5:0]  ld_addr;
    logic [16:0] ld_data;
    logic        start;
    logic        stall;
    logic [16:0] instr;
    logic [5:0]  pc;
    logic        valid;
    logic        busy;
    logic        done;
`ifdef FETCH_CNT_EN
    logic [31:0] fetched_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] mdl_mem [64];

    fetch_stage dut (
        .clk     (clk),
        .rst     (rst),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .stall   (stall),
        .instr   (instr),
        .pc      (pc),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
`ifdef FETCH_CNT_EN
        ,
        .fetched_cnt (fetched_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] rand_word();
        logic [16:0] w;
        w = 17'($urandom);
        if (w == HALT) w = 17'h0ACE5;
        return w;
    endfunction

    task automatic load_word(input logic [5:0] a, input logic [16:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_we = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_instr"}, instr, NOP);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_done"},  done, 0);
        check_eq({tag, "_pc"},    pc, 0);
`ifdef FETCH_CNT_EN
        check_eq({tag, "_cnt"}, fetched_cnt, 0);
`endif
    endtask

    // mode 0: stalls from mask (bit = cycle after start edge); mode 1: random stalls.
    task automatic run_prog(input bit sw, input logic [5:0] sw_a, input logic [16:0] sw_d,
                            input int mode, input logic [31:0] mask, input bit noise);
        logic [16:0] q[$];
        int          final_pc;
        bit          end_at_halt;
        int          issued;
        bit          fin;
        logic        st;
        logic [5:0]  pc_before;
        logic [16:0] exp_w;
        bit          exp_done;

        if (sw) begin
            ld_we = 1'b1; ld_addr = sw_a; ld_data = sw_d;
            mdl_mem[sw_a] = sw_d;
        end
        // Expected stream: words from address 0 up to the sentinel or the last address.
        end_at_halt = 1'b0;
        final_pc = 63;
        for (int k = 0; k < 64; k++) begin
            if (mdl_mem[k] == HALT) begin
                end_at_halt = 1'b1;
                final_pc = k;
                break;
            end
            q.push_back(mdl_mem[k]);
        end

        start = 1'b1;
        step();
        start = 1'b0; ld_we = 1'b0;
        check_eq("start_busy",  busy, 1);
        check_eq("start_done",  done, 0);
        check_eq("start_valid", valid, 0);
        check_eq("start_pc",    pc, 0);
`ifdef FETCH_CNT_EN
        check_eq("start_cnt", fetched_cnt, 0);
`endif

        issued = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (mode == 1) st = ($urandom_range(0, 3) == 0);
            else           st = (cyc < 32) ? mask[cyc] : 1'b0;
            stall = st;
            if (noise) begin
                ld_we   = 1'($urandom_range(0, 1));
                ld_addr = 6'($urandom);
                ld_data = 17'($urandom);
                start   = ($urandom_range(0, 7) == 0);
            end
            pc_before = pc;
            step();
            stall = 1'b0; ld_we = 1'b0; start = 1'b0;
            if (st) begin
                check_eq("stall_valid", valid, 0);
                check_eq("stall_instr", instr, NOP);
                check_eq("stall_pc",    pc, pc_before);
                check_eq("stall_busy",  busy, 1);
            end else if (valid) begin
                if (q.size() == 0) begin
                    check_eq("extra_issue", instr, NOP);
                    check_eq("extra_issue_valid", valid, 0);
                    fin = 1'b1;
                end else begin
                    exp_w = q.pop_front();
                    issued++;
                    check_eq("issue_word", instr, exp_w);
                    exp_done = (q.size() == 0) && !end_at_halt;
                    check_eq("issue_done", done, exp_done);
                    check_eq("issue_pc", pc, exp_done ? 63 : issued);
                    if (exp_done) fin = 1'b1;
                end
            end else begin
                check_eq("halt_entry_done",  done, 1);
                check_eq("halt_entry_busy",  busy, 0);
                check_eq("halt_entry_instr", instr, NOP);
                check_eq("halt_entry_pc",    pc, final_pc);
                check_eq("halt_entry_left",  q.size(), 0);
                fin = 1'b1;
            end
        end
        if (!fin) check_eq("run_timeout", 0, 1);

        step();
        check_eq("halt_valid", valid, 0);
        check_eq("halt_instr", instr, NOP);
        check_eq("halt_done",  done, 1);
        check_eq("halt_busy",  busy, 0);
        check_eq("halt_pc",    pc, final_pc);
`ifdef FETCH_CNT_EN
        check_eq("halt_cnt", fetched_cnt, issued);
`endif
    endtask

    initial begin
        int len;
        rst = 1'b1; ld_we = 1'b0; ld_addr = 6'd0; ld_data = 17'd0;
        start = 1'b0; stall = 1'b0;
        for (int i = 0; i < 64; i++) mdl_mem[i] = NOP;
        step(); step();
        rst = 1'b0;
        check_reset_state("reset");

        // Two real words then the sentinel.
        load_word(6'd0, 17'h04443);
        load_word(6'd1, 17'h08C85);
        load_word(6'd2, HALT);
        run_prog(1'b0, 6'd0, NOP, 0, 32'h0, 1'b0);

        // Four words, two-cycle stall after the second issue.
        for (int i = 0; i < 4; i++) load_word(6'(i), rand_word());
        load_word(6'd4, HALT);
        run_prog(1'b0, 6'd0, NOP, 0, 32'h0000_000C, 1'b0);

        // Reset while running at pc=5.
        for (int i = 0; i < 10; i++) load_word(6'(i), rand_word());
        load_word(6'd10, HALT);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("pre_rst_pc", pc, 5);
        rst = 1'b1; step(); rst = 1'b0;
        check_reset_state("midrun_rst");
        step();
        check_reset_state("midrun_idle");

        // Three words with one stall.
        for (int i = 0; i < 3; i++) load_word(6'(i), rand_word());
        load_word(6'd3, HALT);
        run_prog(1'b0, 6'd0, NOP, 0, 32'h0000_0002, 1'b0);

        // Full memory without a sentinel: 64 issues, no wrap.
        for (int i = 0; i < 64; i++) load_word(6'(i), rand_word());
        run_prog(1'b0, 6'd0, NOP, 0, 32'h0, 1'b0);

        // Write of address 0 on the start edge, loader/start noise during RUN, then re-run.
        run_prog(1'b1, 6'd0, 17'h0A0A1, 0, 32'h0, 1'b1);
        run_prog(1'b0, 6'd0, NOP, 1, 32'h0, 1'b0);

        // Randomized programs.
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(0, 70);
            for (int i = 0; i < 64 && i < len; i++) load_word(6'(i), rand_word());
            if (len < 64) load_word(6'(len), HALT);
            run_prog(1'b0, 6'd0, NOP, 1, 32'h0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
